// File: rtl/gpio_ctrl_if.sv
// Avalon-MM slave bus bundle for gpio_ctrl.
// Signals: address (word), writedata, write, read, chipselect,
// readdata (combinational), waitrequest.
interface gpio_ctrl_if;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic        chipselect;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, writedata, write, read, chipselect,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, writedata, write, read, chipselect,
    output readdata, waitrequest
  );
endinterface

// File: rtl/gpio_ctrl.sv
// GPIO controller: per-bit direction, output data with atomic
// set/clear/toggle, synchronised input path and edge-detect interrupts.
// Ports:
//   clock  - single clock
//   resetn - synchronous reset, asserted high
//   bus    - Avalon-MM slave (zero wait states, combinational readdata)
//   irq    - level interrupt, |(STATUS & IRQ_EN)
//   gpio   - pins, driven with DOUT where DDR=1, else high-Z
module gpio_ctrl #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DDR_RESET   = '0
) (
  input  logic             clock,
  input  logic             resetn,
  gpio_ctrl_if.slave       bus,
  output logic             irq,
  inout  wire  [WIDTH-1:0] gpio
);

  localparam int unsigned MODE_PINS = (WIDTH < 16) ? WIDTH : 16;
  localparam int unsigned MODE_W    = 2 * MODE_PINS;
  localparam int unsigned ARM_MAX   = SYNC_STAGES + 1;
  localparam int unsigned CNT_W     = $clog2(ARM_MAX + 1);

  logic [WIDTH-1:0]  ddr_q, ddr_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [WIDTH-1:0]  irq_en_q, irq_en_d;
  logic [MODE_W-1:0] irq_mode_q, irq_mode_d;
  logic [WIDTH-1:0]  status_q, status_d;
  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  din_d_q;
  logic [CNT_W-1:0]  arm_cnt_q, arm_cnt_d;

  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  wd;
  logic [WIDTH-1:0]  w1c;
  logic [WIDTH-1:0]  edge_hit;
  logic              wr;
  logic              armed;
  logic              unused_ok;

  assign din   = sync_q[SYNC_STAGES-1];
  assign wd    = bus.writedata[WIDTH-1:0];
  assign wr    = bus.write & bus.chipselect;
  assign armed = (arm_cnt_q == CNT_W'(ARM_MAX));
  assign w1c   = (wr && bus.address == 4'd8) ? wd : '0;

  // Reads are side-effect free; upper writedata bits are ignored.
  assign unused_ok = ^{bus.read, bus.writedata};

  // Pin drivers follow the registers directly.
  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    assign gpio[g] = ddr_q[g] ? dout_q[g] : 1'bz;
  end

  // Per-pin edge qualification; pins above the mode field are rising-only.
  for (genvar g = 0; g < WIDTH; g++) begin : g_edge
    logic rise, fall;
    assign rise = din[g] & ~din_d_q[g];
    assign fall = ~din[g] & din_d_q[g];
    if (g < MODE_PINS) begin : g_mode
      logic [1:0] mode;
      assign mode = irq_mode_q[2*g +: 2];
      assign edge_hit[g] = (mode == 2'b00) ? rise :
                           (mode == 2'b01) ? fall :
                           (mode == 2'b10) ? (rise | fall) : 1'b0;
    end else begin : g_fixed
      assign edge_hit[g] = rise;
    end
  end

  // Register writes and status/arming next state.
  always_comb begin
    ddr_d      = ddr_q;
    dout_d     = dout_q;
    irq_en_d   = irq_en_q;
    irq_mode_d = irq_mode_q;
    arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + CNT_W'(1);
    // A new edge wins over a simultaneous W1C of the same bit.
    status_d   = (status_q & ~w1c) | (armed ? edge_hit : '0);
    if (wr) begin
      case (bus.address)
        4'd0:    ddr_d      = wd;
        4'd1:    dout_d     = wd;
        4'd3:    dout_d     = dout_q | wd;
        4'd4:    dout_d     = dout_q & ~wd;
        4'd5:    dout_d     = dout_q ^ wd;
        4'd6:    irq_en_d   = wd;
        4'd7:    irq_mode_d = bus.writedata[MODE_W-1:0];
        default: ;
      endcase
    end
  end

  // State registers, synchroniser chain and previous-DIN flop.
  always_ff @(posedge clock) begin
    if (resetn) begin
      ddr_q      <= DDR_RESET;
      dout_q     <= '0;
      irq_en_q   <= '0;
      irq_mode_q <= '0;
      status_q   <= '0;
      din_d_q    <= '0;
      arm_cnt_q  <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      ddr_q      <= ddr_d;
      dout_q     <= dout_d;
      irq_en_q   <= irq_en_d;
      irq_mode_q <= irq_mode_d;
      status_q   <= status_d;
      din_d_q    <= din;
      arm_cnt_q  <= arm_cnt_d;
      sync_q[0]  <= gpio;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Combinational read mux; unused upper bits read 0.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      4'd0:             bus.readdata = 32'(ddr_q);
      4'd1, 4'd3,
      4'd4, 4'd5:       bus.readdata = 32'(dout_q);
      4'd2:             bus.readdata = 32'(din);
      4'd6:             bus.readdata = 32'(irq_en_q);
      4'd7:             bus.readdata = 32'(irq_mode_q);
      4'd8:             bus.readdata = 32'(status_q);
      default:          bus.readdata = '0;
    endcase
  end

  assign bus.waitrequest = 1'b0;
  assign irq             = |(status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl (WIDTH=8, SYNC_STAGES=2, DDR_RESET=0).
module tb_gpio_ctrl;

  logic       clock;
  logic       resetn;
  logic       irq;
  wire  [7:0] gpio;
  logic [7:0] ext_en;
  logic [7:0] ext_val;

  int checks = 0;
  int errors = 0;

  gpio_ctrl_if bus ();

  gpio_ctrl #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .DDR_RESET  (8'h00)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus),
    .irq   (irq),
    .gpio  (gpio)
  );

  for (genvar g = 0; g < 8; g++) begin : g_ext
    assign gpio[g] = ext_en[g] ? ext_val[g] : 1'bz;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        do_wr;
    logic [3:0]  wr_addr;
    logic [31:0] wd;
    logic [3:0]  rd_addr;
    logic [31:0] exp_rd;
    logic        chk_pins;
    logic [7:0]  exp_pins;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.write      = 1'b1;
    bus.chipselect = 1'b1;
    @(posedge clock);
    #1;
    bus.write      = 1'b0;
    bus.chipselect = 1'b0;
  endtask

  task automatic rd_check(input logic [3:0] addr, input logic [31:0] exp, input string name);
    bus.address    = addr;
    bus.read       = 1'b1;
    bus.chipselect = 1'b1;
    #1;
    check(name, bus.readdata, exp);
    bus.read       = 1'b0;
    bus.chipselect = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_vec(input int i);
    if (vecs[i].do_wr) bus_write(vecs[i].wr_addr, vecs[i].wd);
    rd_check(vecs[i].rd_addr, vecs[i].exp_rd, $sformatf("vec%0d_rd", i));
    if (vecs[i].chk_pins)
      check($sformatf("vec%0d_pins", i), 32'(gpio), 32'(vecs[i].exp_pins));
  endtask

  initial begin
    // Reset-state reads
    vecs[0]  = '{1'b0, 4'd0, 32'h0,        4'd0,  32'h0,  1'b0, 8'h00};
    vecs[1]  = '{1'b0, 4'd0, 32'h0,        4'd1,  32'h0,  1'b0, 8'h00};
    vecs[2]  = '{1'b0, 4'd0, 32'h0,        4'd2,  32'h0,  1'b0, 8'h00};
    vecs[3]  = '{1'b0, 4'd0, 32'h0,        4'd6,  32'h0,  1'b0, 8'h00};
    vecs[4]  = '{1'b0, 4'd0, 32'h0,        4'd7,  32'h0,  1'b0, 8'h00};
    vecs[5]  = '{1'b0, 4'd0, 32'h0,        4'd8,  32'h0,  1'b0, 8'h00};
    vecs[6]  = '{1'b0, 4'd0, 32'h0,        4'd9,  32'h0,  1'b0, 8'h00};
    vecs[7]  = '{1'b0, 4'd0, 32'h0,        4'd12, 32'h0,  1'b0, 8'h00};
    vecs[8]  = '{1'b0, 4'd0, 32'h0,        4'd15, 32'h0,  1'b0, 8'h00};
    // Direction masking and atomic output updates
    vecs[9]  = '{1'b1, 4'd0, 32'hFFFFFFFF, 4'd0,  32'hFF, 1'b1, 8'h00};
    vecs[10] = '{1'b1, 4'd1, 32'h0F,       4'd1,  32'h0F, 1'b1, 8'h0F};
    vecs[11] = '{1'b1, 4'd3, 32'hF0,       4'd3,  32'hFF, 1'b1, 8'hFF};
    vecs[12] = '{1'b1, 4'd4, 32'h03,       4'd1,  32'hFC, 1'b1, 8'hFC};
    vecs[13] = '{1'b1, 4'd5, 32'h81,       4'd5,  32'h7D, 1'b1, 8'h7D};
    vecs[14] = '{1'b1, 4'd9, 32'hFFFFFFFF, 4'd9,  32'h0,  1'b1, 8'h7D};
    vecs[15] = '{1'b1, 4'd2, 32'hFF,       4'd0,  32'hFF, 1'b1, 8'h7D};

    bus.address    = 4'd0;
    bus.writedata  = 32'h0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.chipselect = 1'b0;
    ext_en         = 8'hFF;
    ext_val        = 8'h00;
    resetn         = 1'b1;
    wait_cycles(3);
    resetn = 1'b0;

    for (int i = 0; i < 9; i++) apply_vec(i);
    check("irq_reset", 32'(irq), 32'h0);

    // Hand the pins to the DUT before it drives them
    ext_en = 8'h00;
    for (int i = 9; i < 16; i++) apply_vec(i);

    // Return pins to external drive and clear edges seen so far
    bus_write(4'd0, 32'h0);
    ext_val = 8'h00;
    ext_en  = 8'hFF;
    wait_cycles(4);
    bus_write(4'd8, 32'hFF);
    rd_check(4'd8, 32'h0, "status_cleared");

    // Input latency: pin 3 rises
    bus_write(4'd6, 32'h08);
    ext_val[3] = 1'b1;
    wait_cycles(1);
    rd_check(4'd2, 32'h00, "din_lat1");
    wait_cycles(1);
    rd_check(4'd2, 32'h08, "din_lat2");
    rd_check(4'd8, 32'h00, "status_lat2");
    check("irq_lat2", 32'(irq), 32'h0);
    wait_cycles(1);
    rd_check(4'd8, 32'h08, "status_lat3");
    check("irq_lat3", 32'(irq), 32'h1);
    bus_write(4'd8, 32'h08);
    rd_check(4'd8, 32'h00, "status_w1c");
    check("irq_w1c", 32'(irq), 32'h0);
    bus_write(4'd6, 32'h0);
    ext_val[3] = 1'b0;
    wait_cycles(4);
    rd_check(4'd8, 32'h00, "fall_ignored_rise_mode");

    // Modes: pin 0 falling, pin 1 both edges
    bus_write(4'd7, 32'h9);
    rd_check(4'd7, 32'h9, "irq_mode_rb");
    ext_val[0] = 1'b1;
    wait_cycles(4);
    rd_check(4'd8, 32'h0, "mode_fall_no_rise");
    ext_val[0] = 1'b0;
    wait_cycles(4);
    rd_check(4'd8, 32'h1, "mode_fall_hit");
    ext_val[1] = 1'b1;
    wait_cycles(4);
    rd_check(4'd8, 32'h3, "mode_both_rise");
    bus_write(4'd8, 32'h2);
    rd_check(4'd8, 32'h1, "mode_both_clr");
    ext_val[1] = 1'b0;
    wait_cycles(4);
    rd_check(4'd8, 32'h3, "mode_both_fall");
    bus_write(4'd8, 32'h3);
    rd_check(4'd8, 32'h0, "mode_clear_all");

    // Set-wins race on pin 2: W1C lands on the detection edge
    bus_write(4'd6, 32'h4);
    ext_val[2] = 1'b1;
    wait_cycles(1);
    wait_cycles(1);
    bus_write(4'd8, 32'h4);
    rd_check(4'd8, 32'h4, "race_set_wins");
    check("race_irq", 32'(irq), 32'h1);
    bus_write(4'd8, 32'h4);
    rd_check(4'd8, 32'h0, "race_then_clear");
    ext_val[2] = 1'b0;
    wait_cycles(4);
    bus_write(4'd6, 32'h0);

    // Reset arming with pin 5 held high
    ext_val[5] = 1'b1;
    wait_cycles(4);
    bus_write(4'd8, 32'hFF);
    rd_check(4'd8, 32'h0, "arm_pre_clear");
    resetn = 1'b1;
    wait_cycles(1);
    resetn = 1'b0;
    rd_check(4'd2, 32'h0, "arm_din_reset");
    rd_check(4'd7, 32'h0, "arm_mode_reset");
    bus_write(4'd6, 32'h20);
    for (int c = 0; c < 20; c++) begin
      rd_check(4'd8, 32'h0, $sformatf("arm_status_c%0d", c));
      check($sformatf("arm_irq_c%0d", c), 32'(irq), 32'h0);
      wait_cycles(1);
    end
    rd_check(4'd2, 32'h20, "arm_din_high");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
